text_mode_controller: RTL and testbench
=======================================

Name: text_mode_controller

Overview:
- Character-cell text renderer placed between vga_sync and the pixel output.
- Holds an internal COLS x ROWS text buffer. Sequences one text-buffer read and one font_rom lookup per 8-pixel cell, then serialises the 8-bit glyph row into pixel_out_out.
- Arbitrates the single text-buffer port between the display fetch (priority) and a host write interface with valid/ready.

Parameters:
- COLS, 80, character columns (640/8).
- ROWS, 30, character rows (480/16).
- PIXEL_BITS, 12, colour width of pixel_out_out.
- WIDTH_BITS, 10, width of pixel_x_in.
- HEIGHT_BITS, 10, width of pixel_y_in.
- FG_COLOR, 12'hFFF, colour for a set glyph bit.
- BG_COLOR, 12'h000, colour for a clear glyph bit.

Ports:
- clock_in  in  1  pixel clock.
- reset_n_in  in  1  asynchronous, active-low reset.
- pixel_x_in  in  WIDTH_BITS  from vga_sync pixel_x_out.
- pixel_y_in  in  HEIGHT_BITS  from vga_sync pixel_y_out.
- display_on_in  in  1  from vga_sync display_on_out.
- h_sync_in  in  1  from vga_sync.
- v_sync_in  in  1  from vga_sync, active-low.
- wr_valid_in  in  1  host write request.
- wr_addr_in  in  12  cell index, row*COLS+col.
- wr_data_in  in  8  bit7 = inverse video, bits[6:0] = char code.
- wr_ready_out  out  1  write accepted this cycle when high with wr_valid_in.
- font_addr_out  out  11  to font_rom addr_in, {char[6:0], line[3:0]}.
- font_data_in  in  8  from font_rom data_out; index 0 = leftmost pixel; combinational ROM.
- pixel_out_out  out  PIXEL_BITS  rendered colour.
- display_on_out  out  1  display_on_in delayed 3 cycles.
- h_sync_out  out  1  h_sync_in delayed 3 cycles.
- v_sync_out  out  1  v_sync_in delayed 3 cycles.

Behaviour:
- Clock and reset: one clock, clock_in. Reset is asynchronous and active-low on reset_n_in.
- Reset values:
  - All pipeline registers 0. pixel_out_out 0. display_on_out 0.
  - h_sync_out and v_sync_out = 1 (inactive). wr_ready_out 0 while reset is asserted.
  - Text buffer contents are not reset.
- Port claim: claim = display_on_in && pixel_x_in[2:0]==0. wr_ready_out = !claim, combinational, outside reset.
- Host writes: a write happens on a rising edge with wr_valid_in && wr_ready_out. wr_addr_in >= COLS*ROWS is accepted and dropped.
- Stage 1 (edge t):
  - If claim: buffer read at (pixel_y_in[8:4])*COLS + pixel_x_in[9:3], with a registered read.
  - Register line = pixel_y_in[3:0], bit = pixel_x_in[2:0], display_on and syncs.
- Stage 2 (edge t+1):
  - cur_char = (bit_d1==0) ? buffer_q : char_reg. char_reg <= cur_char.
  - font_addr_out = {cur_char[6:0], line_d1}.
  - Register row_reg <= font_data_in and inv_reg <= cur_char[7] when bit_d1==0; otherwise hold.
  - Register bit_d2.
- Stage 3 (edge t+2):
  - pixel_out_out = display_on_d2 ? ((row_reg[bit_d2] ^ inv_reg) ? FG_COLOR : BG_COLOR) : 0.
- Latency: exactly 3 cycles from pixel coordinates in to pixel_out_out. Syncs and display_on are delayed identically so alignment is kept.
- Same cycle: a write and a claimed read never collide, because writes are blocked on claimed cycles. A write to the cell being displayed takes effect on that cell's next fetch (next line), never mid-cell.
- Blanking: all cycles with display_on_in low are write cycles. pixel_out_out is 0 during blanking.
- Reset mid-frame: the pipeline flushes and outputs return to reset values. After release, the first 3 cycles output pixel 0; rendering resumes at the next cell boundary.
- Line wrap: at pixel_x_in wrap to 0 there is no state to clear; char_reg is refetched at x[2:0]==0.

Test Plan:
1. Reset check: hold reset_n_in=0 mid-frame -> pixel_out_out=0, v_sync_out=1, wr_ready_out=0. Release -> pixel_out_out=0 for 3 cycles.
2. Glyph render: write 0x41 to addr 0 during vertical blank, then run a frame. For y=0..15 and x=0..7, pixel_out_out equals font_rom[{7'h41,y[3:0]}][x] mapped to 12'hFFF/12'h000, appearing 3 cycles after the coordinates.
3. Inverse video: write 0xC1 to addr 81 (row 1, col 1) -> pixels x=8..15, y=16..31 are the bitwise inverse of case 2's colours.
4. Arbitration: hold wr_valid_in=1 through an active line -> wr_ready_out low exactly when display_on_in && x[2:0]==0. Exactly 7 of every 8 active cycles accept. The write count matches the bench model.
5. Out-of-range write: wr_addr_in=2400, data 0x7F -> accepted. Cells 0 and 2399 are unchanged on readback render.
6. Alignment: compare h_sync_out, v_sync_out and display_on_out with the inputs delayed by 3 cycles over one full frame -> zero mismatches. pixel_out_out=0 whenever display_on_out=0.

Source files
------------

// File: rtl/text_mode_controller.sv
// text_mode_controller: character-cell text renderer with a host-writable text buffer.
// Three-stage pipeline per pixel: buffer read, font lookup, glyph-bit serialise.
module text_mode_controller #(
    parameter int COLS = 80,
    parameter int ROWS = 30,
    parameter int PIXEL_BITS = 12,
    parameter int WIDTH_BITS = 10,
    parameter int HEIGHT_BITS = 10,
    parameter logic [PIXEL_BITS-1:0] FG_COLOR = 12'hFFF,
    parameter logic [PIXEL_BITS-1:0] BG_COLOR = 12'h000
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic [WIDTH_BITS-1:0]  pixel_x_in,
    input  logic [HEIGHT_BITS-1:0] pixel_y_in,
    input  logic                   display_on_in,
    input  logic                   h_sync_in,
    input  logic                   v_sync_in,
    input  logic                   wr_valid_in,
    input  logic [11:0]            wr_addr_in,
    input  logic [7:0]             wr_data_in,
    output logic                   wr_ready_out,
    output logic [10:0]            font_addr_out,
    input  logic [7:0]             font_data_in,
    output logic [PIXEL_BITS-1:0]  pixel_out_out,
    output logic                   display_on_out,
    output logic                   h_sync_out,
    output logic                   v_sync_out
);
    localparam int CELLS = COLS * ROWS;

    logic [7:0]  mem [CELLS];
    logic        claim;
    logic [11:0] rd_addr;
    logic [7:0]  buffer_q, char_reg, cur_char, row_reg;
    logic [3:0]  line_d1;
    logic [2:0]  bit_d1, bit_d2;
    logic        de_d1, hs_d1, vs_d1, de_d2, hs_d2, vs_d2, inv_reg;
    logic        unused_bits;

    // The display owns the buffer port on the first pixel of every visible cell.
    assign claim        = display_on_in && pixel_x_in[2:0] == 3'd0;
    assign wr_ready_out = reset_n_in && !claim;
    assign rd_addr      = 12'(pixel_y_in[8:4] * COLS) + 12'(pixel_x_in[9:3]);
    assign unused_bits  = pixel_y_in[9];

    always_ff @(posedge clock_in)
        if (wr_valid_in && wr_ready_out && wr_addr_in < 12'(CELLS))
            mem[wr_addr_in] <= wr_data_in;

    always_comb begin
        cur_char = bit_d1 == 3'd0 ? buffer_q : char_reg;
    end

    assign font_addr_out = {cur_char[6:0], line_d1};

    always_ff @(posedge clock_in or negedge reset_n_in)
        if (!reset_n_in) begin
            buffer_q       <= '0;
            line_d1        <= '0;
            bit_d1         <= '0;
            de_d1          <= 1'b0;
            hs_d1          <= 1'b1;
            vs_d1          <= 1'b1;
            char_reg       <= '0;
            row_reg        <= '0;
            inv_reg        <= 1'b0;
            bit_d2         <= '0;
            de_d2          <= 1'b0;
            hs_d2          <= 1'b1;
            vs_d2          <= 1'b1;
            pixel_out_out  <= '0;
            display_on_out <= 1'b0;
            h_sync_out     <= 1'b1;
            v_sync_out     <= 1'b1;
        end else begin
            if (claim)
                buffer_q <= mem[rd_addr];
            line_d1  <= pixel_y_in[3:0];
            bit_d1   <= pixel_x_in[2:0];
            de_d1    <= display_on_in;
            hs_d1    <= h_sync_in;
            vs_d1    <= v_sync_in;
            char_reg <= cur_char;
            // The glyph row is latched once per cell so mid-cell writes never tear it.
            if (bit_d1 == 3'd0) begin
                row_reg <= font_data_in;
                inv_reg <= cur_char[7];
            end
            bit_d2         <= bit_d1;
            de_d2          <= de_d1;
            hs_d2          <= hs_d1;
            vs_d2          <= vs_d1;
            pixel_out_out  <= de_d2 ? ((row_reg[bit_d2] ^ inv_reg) ? FG_COLOR : BG_COLOR) : '0;
            display_on_out <= de_d2;
            h_sync_out     <= hs_d2;
            v_sync_out     <= vs_d2;
        end
endmodule

// File: tb/tb_text_mode_controller.sv
// tb_text_mode_controller: directed stimulus with a pixel-level reference model
// and a 3-deep expectation queue for the pipeline latency.
module tb_text_mode_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, de, hs, vs, wv;
    logic [9:0]  px, py;
    logic [11:0] wa;
    logic [7:0]  wd;
    logic        wr_ready, de_o, hs_o, vs_o;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [11:0] pix;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int obs_acc = 0;

    typedef struct packed {
        logic [11:0] pix;
        logic        de;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t       q[$];
    logic [7:0] shadow [2400];
    logic [7:0] cell_char;

    text_mode_controller dut (
        .clock_in(clk),
        .reset_n_in(rst_n),
        .pixel_x_in(px),
        .pixel_y_in(py),
        .display_on_in(de),
        .h_sync_in(hs),
        .v_sync_in(vs),
        .wr_valid_in(wv),
        .wr_addr_in(wa),
        .wr_data_in(wd),
        .wr_ready_out(wr_ready),
        .font_addr_out(font_addr),
        .font_data_in(font_data),
        .pixel_out_out(pix),
        .display_on_out(de_o),
        .h_sync_out(hs_o),
        .v_sync_out(vs_o)
    );

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        return {a[3:0], a[7:4]} ^ {a[10:8], 5'd0} ^ 8'h5A;
    endfunction

    assign font_data = font_fn(font_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic hold_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0; px = 10'd3; py = 10'd5; de = 1'b1; hs = 1'b0; vs = 1'b0;
        wv = 1'b1; wa = 12'd0; wd = 8'hFF;
        for (int i = 0; i <= n; i++) begin
            #1;
            check("rst_pix", 32'(pix), 32'd0);
            check("rst_de", 32'(de_o), 32'd0);
            check("rst_hs", 32'(hs_o), 32'd1);
            check("rst_vs", 32'(vs_o), 32'd1);
            check("rst_ready", 32'(wr_ready), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1; de = 1'b0; hs = 1'b1; vs = 1'b1; wv = 1'b0;
        q.delete();
        repeat (3) q.push_back('{pix: 12'd0, de: 1'b0, hs: 1'b1, vs: 1'b1});
    endtask

    task automatic cyc(input int x, input int y, input logic d, input logic h, input logic v,
                       input logic w, input int a, input logic [7:0] dat);
        exp_t       o, e;
        logic [7:0] row;
        logic       claim;
        @(negedge clk);
        o = q.pop_front();
        check("pix", 32'(pix), 32'(o.pix));
        check("de_out", 32'(de_o), 32'(o.de));
        check("hs_out", 32'(hs_o), 32'(o.hs));
        check("vs_out", 32'(vs_o), 32'(o.vs));
        px = 10'(x); py = 10'(y); de = d; hs = h; vs = v; wv = w; wa = 12'(a); wd = dat;
        claim = d && (x % 8 == 0);
        #1;
        check("ready", 32'(wr_ready), 32'(!claim));
        if (w && wr_ready)
            obs_acc++;
        if (claim)
            cell_char = shadow[(y / 16) * 80 + x / 8];
        row = font_fn({cell_char[6:0], 4'(y % 16)});
        e.pix = !d ? 12'h000 : ((row[x % 8] ^ cell_char[7]) ? 12'hFFF : 12'h000);
        e.de = d; e.hs = h; e.vs = v;
        q.push_back(e);
        if (w && !claim) begin
            accepts++;
            if (a < 2400)
                shadow[a] = dat;
        end
    endtask

    task automatic render(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++)
                cyc(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h00);
            for (int k = 0; k < 4; k++)
                cyc(640 + k, y, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        end
    endtask

    initial begin
        rst_n = 1'b0; px = '0; py = '0; de = 1'b0; hs = 1'b1; vs = 1'b1;
        wv = 1'b0; wa = '0; wd = '0; cell_char = '0;
        hold_reset(3);
        // Load rows 0 and 1 (cols 0..7) and the last cell during vertical blank.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 490, 1'b0, 1'b1, 1'b0, 1'b1, i, i == 0 ? 8'h41 : 8'(8'h30 + i));
            cyc(0, 490, 1'b0, 1'b1, 1'b0, 1'b1, 80 + i, i == 1 ? 8'hC1 : 8'(8'h10 + i));
        end
        cyc(0, 491, 1'b0, 1'b0, 1'b0, 1'b1, 2399, 8'h5A);
        render(0, 63, 0, 31);
        // Continuous write request across an active line.
        accepts = 0; obs_acc = 0;
        for (int x = 0; x < 64; x++)
            cyc(x, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1000, 8'h55);
        check("acc_obs", 32'(obs_acc), 32'd56);
        check("acc_model", 32'(obs_acc), 32'(accepts));
        // Out-of-range write is accepted and dropped.
        accepts = 0;
        cyc(0, 492, 1'b0, 1'b1, 1'b0, 1'b1, 2400, 8'h7F);
        check("oor_acc", 32'(accepts), 32'd1);
        render(0, 7, 0, 15);
        render(632, 639, 464, 479);
        // Reset in the middle of a visible line, with a write pending.
        render(0, 19, 5, 5);
        hold_reset(4);
        for (int k = 0; k < 4; k++)
            cyc(700, 6, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h00);
        render(0, 15, 6, 6);
        render(0, 7, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc(700, 7, 1'b0, 1'b1, 1'b1, 1'b0, 0, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
